// File: rtl/rom_arb_pkg.sv
// Shared types and default sizing for the ROM port arbiter.
// The ROM_ARB_STATS_EN macro (used by rom_port_arbiter) enables the statistics counters.
package rom_arb_pkg;

    localparam int ADDR_W_DEF     = 12;
    localparam int DATA_W_DEF     = 8;
    localparam int STARVE_MAX_DEF = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DATA = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rom_arb_sat_cnt.sv
// Saturating up-counter with synchronous clear; used for the starve timer and the stats.
module rom_arb_sat_cnt #(
    parameter int          W   = 16,
    parameter int unsigned MAX = 32'd65535
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_r;

    // Count register: clear wins over increment, holds at MAX_V
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (inc && (cnt_r != MAX_V)) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/rom_port_arbiter.sv
// Single-port ROM arbiter: display fetches always win, host reads fill idle slots.
// Define ROM_ARB_STATS_EN to build the host-read and blocked-cycle statistics counters.
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    output logic              host_starve,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_ad,
    input  logic [DATA_W-1:0] rom_dout,
    output logic [15:0]       stat_host_reads,
    output logic [15:0]       stat_block_cycles
);
    localparam int              SC_W   = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_MAX);

    arb_state_t        state_r;
    logic              disp_valid_r;
    logic [DATA_W-1:0] host_rdata_r;
    logic [SC_W-1:0]   starve_cnt_s;
    logic              host_issue_s;
    logic              blocked_s;
    logic              starve_clr_s;

    assign host_issue_s = host_req & ~disp_req;
    assign blocked_s    = host_req & disp_req;
    assign starve_clr_s = host_issue_s | ~host_req;

    // ROM port mux: display has absolute priority, bus parks at zero when unused
    always_comb begin
        rom_ce = 1'b0;
        rom_ad = '0;
        if (disp_req) begin
            rom_ce = 1'b1;
            rom_ad = disp_addr;
        end else if (host_issue_s) begin
            rom_ce = 1'b1;
            rom_ad = host_addr;
        end else begin
            rom_ce = 1'b0;
            rom_ad = '0;
        end
    end

    // Host FSM plus display valid and host data hold registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            disp_valid_r <= 1'b0;
            host_rdata_r <= '0;
        end else begin
            disp_valid_r <= disp_req;
            if (state_r == DATA) begin
                host_rdata_r <= rom_dout;
            end else begin
                host_rdata_r <= host_rdata_r;
            end
            case (state_r)
                IDLE, WAIT, DATA: begin
                    if (host_issue_s) begin
                        state_r <= DATA;
                    end else if (host_req) begin
                        state_r <= WAIT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // In DATA the ROM output already holds the host word, so it is forwarded in that cycle
    assign host_ack    = host_issue_s;
    assign host_rvalid = (state_r == DATA);
    assign host_rdata  = host_rvalid ? rom_dout : host_rdata_r;
    assign disp_data   = rom_dout;
    assign disp_valid  = disp_valid_r;
    assign host_starve = (starve_cnt_s == SC_MAX);

    rom_arb_sat_cnt #(.W(SC_W), .MAX(STARVE_MAX)) u_starve_cnt (
        .clk (clk),
        .rst (rst),
        .clr (starve_clr_s),
        .inc (blocked_s),
        .cnt (starve_cnt_s)
    );

`ifdef ROM_ARB_STATS_EN
    rom_arb_sat_cnt #(.W(16), .MAX(32'd65535)) u_stat_reads (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (host_issue_s),
        .cnt (stat_host_reads)
    );

    rom_arb_sat_cnt #(.W(16), .MAX(32'd65535)) u_stat_block (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (blocked_s),
        .cnt (stat_block_cycles)
    );
`else
    assign stat_host_reads   = 16'h0000;
    assign stat_block_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter against a cycle-level behavioural model.
module tb_rom_port_arbiter;
    import rom_arb_pkg::*;

    localparam int SM = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        disp_req = 1'b0;
    logic [11:0] disp_addr = 12'h000;
    logic [7:0]  disp_data;
    logic        disp_valid;
    logic        host_req = 1'b0;
    logic [11:0] host_addr = 12'h000;
    logic        host_ack;
    logic [7:0]  host_rdata;
    logic        host_rvalid;
    logic        host_starve;
    logic        rom_ce;
    logic [11:0] rom_ad;
    logic [7:0]  rom_dout = 8'h00;
    logic [15:0] stat_host_reads;
    logic [15:0] stat_block_cycles;

    logic [7:0]  rom [0:4095];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic        pv_disp;
    logic [11:0] pv_daddr;
    logic        pv_ack;
    logic [11:0] pv_haddr;
    logic [7:0]  last_hdata;
    int          blk;
    logic [15:0] m_reads;
    logic [15:0] m_block;

    rom_port_arbiter #(.ADDR_W(12), .DATA_W(8), .STARVE_MAX(SM)) dut (
        .clk               (clk),
        .rst               (rst),
        .disp_req          (disp_req),
        .disp_addr         (disp_addr),
        .disp_data         (disp_data),
        .disp_valid        (disp_valid),
        .host_req          (host_req),
        .host_addr         (host_addr),
        .host_ack          (host_ack),
        .host_rdata        (host_rdata),
        .host_rvalid       (host_rvalid),
        .host_starve       (host_starve),
        .rom_ce            (rom_ce),
        .rom_ad            (rom_ad),
        .rom_dout          (rom_dout),
        .stat_host_reads   (stat_host_reads),
        .stat_block_cycles (stat_block_cycles)
    );

    always #5 clk = ~clk;

    // Single-port ROM with one-cycle registered read
    always @(posedge clk) begin
        if (rom_ce) rom_dout <= rom[rom_ad];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        pv_disp = 1'b0; pv_daddr = 12'h000; pv_ack = 1'b0; pv_haddr = 12'h000;
        last_hdata = 8'h00; blk = 0; m_reads = 16'h0000; m_block = 16'h0000;
    endtask

    // Drive one cycle, check every output against the model, then advance one edge
    task automatic step(input logic dr, input logic [11:0] da, input logic hr, input logic [11:0] ha);
        logic       ack;
        logic [7:0] exp_hd;
        disp_req = dr; disp_addr = da; host_req = hr; host_addr = ha;
        ack = hr && !dr;
        #1;
        chk("disp_valid", 32'(disp_valid), 32'(pv_disp));
        if (pv_disp) chk("disp_data", 32'(disp_data), 32'(rom[pv_daddr]));
        chk("host_rvalid", 32'(host_rvalid), 32'(pv_ack));
        if (pv_ack) last_hdata = rom[pv_haddr];
        exp_hd = last_hdata;
        chk("host_rdata", 32'(host_rdata), 32'(exp_hd));
        chk("host_starve", 32'(host_starve), 32'(blk >= SM));
`ifdef ROM_ARB_STATS_EN
        chk("stat_reads", 32'(stat_host_reads), 32'(m_reads));
        chk("stat_block", 32'(stat_block_cycles), 32'(m_block));
`else
        chk("stat_reads", 32'(stat_host_reads), 32'd0);
        chk("stat_block", 32'(stat_block_cycles), 32'd0);
`endif
        chk("rom_ce", 32'(rom_ce), 32'(dr || hr));
        chk("rom_ad", 32'(rom_ad), 32'(dr ? da : (hr ? ha : 12'h000)));
        chk("host_ack", 32'(host_ack), 32'(ack));
        @(posedge clk);
        pv_disp = dr; pv_daddr = da; pv_ack = ack; pv_haddr = ha;
        if (ack || !hr) blk = 0;
        else if (blk < SM) blk = blk + 1;
        if (ack && m_reads != 16'hFFFF) m_reads = m_reads + 16'd1;
        if (hr && dr && m_block != 16'hFFFF) m_block = m_block + 16'd1;
        #1;
    endtask

    task automatic do_reset();
        disp_req = 1'b0; host_req = 1'b0; disp_addr = 12'h000; host_addr = 12'h000;
        rst = 1'b0;
        #1;
        chk("rst_disp_valid", 32'(disp_valid), 32'd0);
        chk("rst_host_ack", 32'(host_ack), 32'd0);
        chk("rst_host_rvalid", 32'(host_rvalid), 32'd0);
        chk("rst_host_rdata", 32'(host_rdata), 32'd0);
        chk("rst_host_starve", 32'(host_starve), 32'd0);
        chk("rst_rom_ce", 32'(rom_ce), 32'd0);
        chk("rst_rom_ad", 32'(rom_ad), 32'd0);
        chk("rst_stat_reads", 32'(stat_host_reads), 32'd0);
        chk("rst_stat_block", 32'(stat_block_cycles), 32'd0);
        chk("rst_state", 32'(dut.state_r), 32'(IDLE));
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_clear();
    endtask

    initial begin
        logic        pend;
        logic        dr;
        logic        hr;
        logic [11:0] ha;
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        model_clear();
        do_reset();

        // Display fetch with idle host
        step(1'b1, 12'h010, 1'b0, 12'h000);
        step(1'b0, 12'h000, 1'b0, 12'h000);

        // Host blocked five cycles, then acked
        for (int i = 0; i < 5; i++) step(1'b1, 12'(12'h100 + i), 1'b1, 12'hABC);
        step(1'b0, 12'h000, 1'b1, 12'hABC);
        step(1'b0, 12'h000, 1'b0, 12'h000);
        chk("abc_data", 32'(host_rdata), 32'(rom[12'hABC]));
        step(1'b0, 12'h000, 1'b0, 12'h000);

        // Starvation: flag must appear only after SM blocked cycles
        for (int i = 0; i < SM + 3; i++) begin
            if (i == SM - 1) chk("starve_early", 32'(host_starve), 32'd0);
            step(1'b1, 12'(12'h200 + i), 1'b1, 12'h555);
        end
        chk("starve_set", 32'(host_starve), 32'd1);
        step(1'b0, 12'h000, 1'b1, 12'h555);
        chk("starve_clr", 32'(host_starve), 32'd0);
        step(1'b0, 12'h000, 1'b0, 12'h000);

        // Back-to-back host reads with stepping address
        for (int i = 0; i < 8; i++) step(1'b0, 12'h000, 1'b1, 12'(12'h3F0 + i));
        step(1'b0, 12'h000, 1'b0, 12'h000);

        // Withdrawal after three blocked cycles
        for (int i = 0; i < 3; i++) step(1'b1, 12'(12'h020 + i), 1'b1, 12'h777);
        step(1'b0, 12'h000, 1'b0, 12'h000);
        chk("withdraw_cnt", 32'(dut.starve_cnt_s), 32'd0);
        step(1'b0, 12'h000, 1'b0, 12'h000);

        // Reset in the cycle following a host ack
        step(1'b0, 12'h000, 1'b1, 12'h123);
        do_reset();
        step(1'b0, 12'h000, 1'b0, 12'h000);
        step(1'b0, 12'h000, 1'b0, 12'h000);

        // Randomised traffic obeying the address-hold rule
        pend = 1'b0;
        ha   = 12'h000;
        for (int i = 0; i < 400; i++) begin
            dr = ($urandom_range(0, 2) != 0);
            if (pend) begin
                hr = ($urandom_range(0, 7) != 0);
            end else begin
                hr = $urandom_range(0, 1) == 1;
                ha = 12'($urandom);
            end
            step(dr, 12'($urandom), hr, ha);
            pend = hr && dr;
        end
        step(1'b0, 12'h000, 1'b0, 12'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
